// File: rtl/arith_pkg.sv
// Shared types and arithmetic helpers for the operand-pair statistics unit.
// Helpers work on fixed maximum widths; callers pass the real widths and truncate the result.
package arith_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [2:0] {
    LT = 3'b100,
    EQ = 3'b010,
    GT = 3'b001
  } cmp_t;

  // sum holds the exact (w+1)-bit sum of the extended operands in its low bits.
  function automatic logic sum_ovf(input logic [MAX_W:0] sum, input int w, input logic sgn);
    logic top;
    logic nxt;
    top = |(sum & ((MAX_W + 1)'(1) << w));
    nxt = |(sum & ((MAX_W + 1)'(1) << (w - 1)));
    return sgn ? (top ^ nxt) : top;
  endfunction

  function automatic logic [MAX_W-1:0] sat_add_w(input logic [MAX_W:0] sum, input int w,
                                                 input logic sgn, input logic sat);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] msb;
    logic [MAX_W-1:0] res;
    logic             top;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    msb  = MAX_W'(1) << (w - 1);
    top  = |(sum & ((MAX_W + 1)'(1) << w));
    res  = sum[MAX_W-1:0] & mask;
    if (sat && sum_ovf(sum, w, sgn)) begin
      if (!sgn)    res = mask;
      else if (top) res = msb;
      else          res = msb - MAX_W'(1);
    end
    return res;
  endfunction

  // The accumulator is reinterpreted per sample: signed view when sgn=1, unsigned otherwise.
  function automatic logic [63:0] sat_ext_acc(input logic [63:0] acc, input logic [MAX_W-1:0] sample,
                                              input int w, input int acc_w, input logic sgn);
    logic        [63:0] wmask;
    logic        [63:0] amask;
    logic signed [63:0] x;
    logic signed [63:0] y;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    wmask = {64{1'b1}} >> (64 - w);
    amask = {64{1'b1}} >> (64 - acc_w);
    x = 64'(sample) & wmask;
    y = acc & amask;
    if (sgn) begin
      if (|(x & (64'(1) << (w - 1))))     x = x | ~wmask;
      if (|(y & (64'(1) << (acc_w - 1)))) y = y | ~amask;
      hi = $signed(amask >> 1);
      lo = ~hi;
    end else begin
      hi = $signed(amask);
      lo = '0;
    end
    s = x + y;
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s & amask;
  endfunction

endpackage

// File: rtl/arith_stat_unit_stat_accum.sv
// Second pipeline stage: finishes the sum (wrap/saturate), then updates the
// saturating accumulator and the sticky-at-max sample counter.
module stat_accum
  import arith_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W:0]       sum,
  input  cmp_t             cmp,
  input  logic             sgn,
  input  logic             sat,
  input  logic             clear,
  output logic             out_valid,
  output logic [W-1:0]     ans1,
  output logic [2:0]       ans2,
  output logic [ACC_W-1:0] ans3,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  logic [W-1:0]     ans1_next;
  logic             ovf_next;
  logic [ACC_W-1:0] ans3_next;
  logic [CNT_W-1:0] cnt_next;

  // A clear restarts the statistics from this very sample.
  always_comb begin
    ans1_next = W'(sat_add_w((MAX_W + 1)'(sum), W, sgn, sat));
    ovf_next  = sum_ovf((MAX_W + 1)'(sum), W, sgn);
    ans3_next = ACC_W'(sat_ext_acc(clear ? 64'(0) : 64'(ans3), MAX_W'(ans1_next), W, ACC_W, sgn));
    if (clear)     cnt_next = CNT_W'(1);
    else if (&cnt) cnt_next = cnt;
    else           cnt_next = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ans1      <= '0;
      ans2      <= '0;
      ans3      <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ans1 <= ans1_next;
        ans2 <= cmp;
        ans3 <= ans3_next;
        ovf  <= ovf_next;
        cnt  <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/arith_stat_unit.sv
// Two-stage streaming add/compare unit with running statistics.
// Stage 1 (here) forms the exact sum and compare flags; stage 2 lives in stat_accum.
module arith_stat_unit
  import arith_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             sgn,
  input  logic             sat,
  input  logic             clear,
  output logic             out_valid,
  output logic [W-1:0]     ans1,
  output logic [2:0]       ans2,
  output logic [ACC_W-1:0] ans3,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  logic [W:0] a_ext;
  logic [W:0] b_ext;
  cmp_t       cmp_next;

  logic       s1_valid;
  logic [W:0] s1_sum;
  cmp_t       s1_cmp;
  logic       s1_sgn;
  logic       s1_sat;
  logic       s1_clear;

  // One extra bit keeps the sum exact and lets a single signed compare serve both modes.
  always_comb begin
    a_ext = sgn ? {a[W-1], a} : {1'b0, a};
    b_ext = sgn ? {b[W-1], b} : {1'b0, b};
    if ($signed(a_ext) < $signed(b_ext)) cmp_next = LT;
    else if (a_ext == b_ext)             cmp_next = EQ;
    else                                 cmp_next = GT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_cmp   <= EQ;
      s1_sgn   <= 1'b0;
      s1_sat   <= 1'b0;
      s1_clear <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum   <= a_ext + b_ext;
        s1_cmp   <= cmp_next;
        s1_sgn   <= sgn;
        s1_sat   <= sat;
        s1_clear <= clear;
      end
    end
  end

  stat_accum #(
    .W     (W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_stat_accum (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .sum       (s1_sum),
    .cmp       (s1_cmp),
    .sgn       (s1_sgn),
    .sat       (s1_sat),
    .clear     (s1_clear),
    .out_valid (out_valid),
    .ans1      (ans1),
    .ans2      (ans2),
    .ans3      (ans3),
    .ovf       (ovf),
    .cnt       (cnt)
  );

endmodule

// File: tb/tb_arith_stat_unit.sv
// Directed bench for arith_stat_unit at W=4, ACC_W=12, CNT_W=8: a table of
// isolated samples with hand-computed results plus pipelined corner sequences.
module tb_arith_stat_unit;

  localparam int W     = 4;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;

  localparam logic [2:0] C_LT = 3'b100;
  localparam logic [2:0] C_EQ = 3'b010;
  localparam logic [2:0] C_GT = 3'b001;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic        sgn;
    logic        sat;
    logic        clear;
    logic [3:0]  ans1;
    logic [2:0]  ans2;
    logic        ovf;
    logic [11:0] ans3;
    logic [7:0]  cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             sgn;
  logic             sat;
  logic             clear;
  logic             out_valid;
  logic [W-1:0]     ans1;
  logic [2:0]       ans2;
  logic [ACC_W-1:0] ans3;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  vec_t vecs [14];

  arith_stat_unit #(
    .W     (W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .sat       (sat),
    .clear     (clear),
    .out_valid (out_valid),
    .ans1      (ans1),
    .ans2      (ans2),
    .ans3      (ans3),
    .ovf       (ovf),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, then returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic [3:0] ia, input logic [3:0] ib, input logic isgn,
                               input logic isat, input logic iclr, input logic ivalid);
    a        = ia;
    b        = ib;
    sgn      = isgn;
    sat      = isat;
    clear    = iclr;
    in_valid = ivalid;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkSample(input string tag, input logic [3:0] e1, input logic [2:0] e2,
                             input logic eo, input logic [11:0] e3, input logic [7:0] ec);
    checkOutput($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(1));
    checkOutput($sformatf("%s.ans1", tag), 32'(ans1), 32'(e1));
    checkOutput($sformatf("%s.ans2", tag), 32'(ans2), 32'(e2));
    checkOutput($sformatf("%s.ovf", tag), 32'(ovf), 32'(eo));
    checkOutput($sformatf("%s.ans3", tag), 32'(ans3), 32'(e3));
    checkOutput($sformatf("%s.cnt", tag), 32'(cnt), 32'(ec));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(0));
    checkOutput($sformatf("%s.ans1", tag), 32'(ans1), 32'(0));
    checkOutput($sformatf("%s.ans2", tag), 32'(ans2), 32'(0));
    checkOutput($sformatf("%s.ovf", tag), 32'(ovf), 32'(0));
    checkOutput($sformatf("%s.ans3", tag), 32'(ans3), 32'(0));
    checkOutput($sformatf("%s.cnt", tag), 32'(cnt), 32'(0));
  endtask

  initial begin
    // Each row runs in isolation but the statistics carry over from row to row.
    vecs[0]  = '{4'h3, 4'h1, 1'b0, 1'b0, 1'b0, 4'h4, C_GT, 1'b0, 12'h004, 8'd1};
    vecs[1]  = '{4'hE, 4'h1, 1'b1, 1'b0, 1'b0, 4'hF, C_LT, 1'b0, 12'h003, 8'd2};
    vecs[2]  = '{4'hE, 4'h1, 1'b0, 1'b0, 1'b0, 4'hF, C_GT, 1'b0, 12'h012, 8'd3};
    vecs[3]  = '{4'h7, 4'h1, 1'b1, 1'b1, 1'b0, 4'h7, C_GT, 1'b1, 12'h019, 8'd4};
    vecs[4]  = '{4'h7, 4'h1, 1'b1, 1'b0, 1'b0, 4'h8, C_GT, 1'b1, 12'h011, 8'd5};
    vecs[5]  = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'hF, C_EQ, 1'b1, 12'h020, 8'd6};
    vecs[6]  = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'hE, C_EQ, 1'b1, 12'h02E, 8'd7};
    vecs[7]  = '{4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, C_GT, 1'b0, 12'h001, 8'd1};
    vecs[8]  = '{4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 4'h8, C_EQ, 1'b1, 12'hFF9, 8'd2};
    vecs[9]  = '{4'h8, 4'h7, 1'b1, 1'b0, 1'b0, 4'hF, C_LT, 1'b0, 12'hFF8, 8'd3};
    vecs[10] = '{4'h8, 4'h7, 1'b0, 1'b0, 1'b0, 4'hF, C_GT, 1'b0, 12'hFFF, 8'd4};
    vecs[11] = '{4'h0, 4'h1, 1'b0, 1'b0, 1'b1, 4'h1, C_LT, 1'b0, 12'h001, 8'd1};
    vecs[12] = '{4'hC, 4'hD, 1'b1, 1'b1, 1'b0, 4'h9, C_LT, 1'b0, 12'hFFA, 8'd2};
    vecs[13] = '{4'h9, 4'hA, 1'b1, 1'b0, 1'b0, 4'h3, C_LT, 1'b1, 12'hFFD, 8'd3};

    reset    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sgn      = 1'b0;
    sat      = 1'b0;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].sat, vecs[i].clear, 1'b1);
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkSample($sformatf("vec%0d", i), vecs[i].ans1, vecs[i].ans2, vecs[i].ovf,
                  vecs[i].ans3, vecs[i].cnt);
    end

    // Outputs hold while idle, and a clear without in_valid is ignored.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("hold.out_valid", 32'(out_valid), 32'(0));
    checkOutput("hold.ans1", 32'(ans1), 32'(4'h3));
    checkOutput("hold.cnt", 32'(cnt), 32'(3));
    applyStimulus(4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSample("noclr", 4'h2, C_EQ, 1'b0, 12'hFFF, 8'd4);

    // Back-to-back stream: output of sample k-1 is visible after sample k is driven.
    for (int k = 0; k < 7; k++) begin
      if (k < 5)       applyStimulus(4'h2, 4'h2, 1'b0, 1'b0, (k == 0), 1'b1);
      else if (k == 5) applyStimulus(4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      else             applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k >= 1 && k <= 5)
        checkSample($sformatf("stream%0d", k - 1), 4'h4, C_EQ, 1'b0, 12'(4 * k), 8'(k));
      else if (k == 6)
        checkSample("stream_clear", 4'h1, C_GT, 1'b0, 12'h001, 8'd1);
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_end.out_valid", 32'(out_valid), 32'(0));

    // Reset with samples in flight: the second one must never emerge.
    applyStimulus(4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkAllZero("midreset");
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midreset_drop.out_valid", 32'(out_valid), 32'(0));
    applyStimulus(4'h6, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSample("after_reset", 4'h7, C_GT, 1'b0, 12'h007, 8'd1);

    // Counter sticks at its maximum.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (299) applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt_limit.cnt", 32'(cnt), 32'(255));
    checkOutput("cnt_limit.ans3", 32'(ans3), 32'(0));

    // Signed accumulator clamps at its most negative value.
    applyStimulus(4'h8, 4'h8, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (259) applyStimulus(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("acc_limit.ans3", 32'(ans3), 32'(12'h800));
    checkOutput("acc_limit.cnt", 32'(cnt), 32'(255));
    checkOutput("acc_limit.ans1", 32'(ans1), 32'(4'h8));
    checkOutput("acc_limit.ovf", 32'(ovf), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
